// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM states and opcode dispatch shared by the SPI flash responder.
package spi_flash_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDID = 8'h9F;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ_DATA, PROG_DATA, TX_FIXED, IGNORE} state_t;
  function automatic state_t op_state(input logic [7:0] op);
    return (op == OP_RDID || op == OP_RDSR) ? TX_FIXED :
           (op == OP_READ || op == OP_PP)   ? ADDR     : IGNORE;
  endfunction
endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pins and byte-wide memory port of the flash responder.
interface spi_flash_responder_if #(parameter int ADDR_W = 24);
  logic              spi_sck;
  logic              spi_csn;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic              mem_busy;
  logic              active;
  modport slave (
    input  spi_sck, spi_csn, spi_mosi, mem_rdata, mem_busy,
    output spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, active
  );
  modport master (
    output spi_sck, spi_csn, spi_mosi, mem_rdata, mem_busy,
    input  spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, active
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser for an asynchronous pin with rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {r_meta, r_sync, r_prev} <= {3{RST_VAL}};
    else {r_meta, r_sync, r_prev} <= {i_d, r_meta, r_sync};
  end
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 25-series flash emulator (RDID, RDSR, WREN, WRDI, READ, PP)
// forwarding array accesses to a byte-wide memory port.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int          ADDR_W   = 24,
  parameter int          PAGE_W   = 8
) (
  input logic             clk,
  input logic             reset,
  spi_flash_responder_if.slave bus
);
  state_t            r_state, w_next;
  logic              w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall, w_byte_done;
  logic              r_mosi_meta, r_mosi, r_sel, r_wel, r_sr, r_read, r_rd, r_wr, r_load;
  logic [2:0]        r_bitcnt;
  logic [1:0]        r_addr_cnt;
  logic [7:0]        r_rx, r_tx, r_wdata, w_byte, w_status;
  logic [15:0]       r_fixed;
  logic [ADDR_W-1:0] r_addr;
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .i_d(bus.spi_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  // csn resets high so a deselected bus never looks selected after reset
  spi_sync_edge #(.RST_VAL(1'b1)) u_csn (
    .clk(clk), .reset(reset), .i_d(bus.spi_csn), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );
  assign w_byte      = {r_rx[6:0], r_mosi};
  assign w_status    = {6'b0, r_wel, bus.mem_busy};
  assign w_byte_done = r_sel && !w_csn_rise && w_sck_rise && r_bitcnt == 3'd7;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_csn_rise) w_next = IDLE;
    else if (w_csn_fall) w_next = CMD;
    else if (w_byte_done)
      w_next = (r_state == CMD) ? op_state(w_byte) :
               (r_state == ADDR && r_addr_cnt == 2'd2) ? (r_read ? READ_DATA : r_wel ? PROG_DATA : IGNORE) :
               r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mosi_meta <= 1'b0;
      r_mosi      <= 1'b0;
      r_sel       <= 1'b0;
      r_wel       <= 1'b0;
      r_sr        <= 1'b0;
      r_read      <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_load      <= 1'b0;
      r_bitcnt    <= '0;
      r_addr_cnt  <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_wdata     <= '0;
      r_fixed     <= '0;
      r_addr      <= '0;
    end else begin
      r_mosi_meta <= bus.spi_mosi;
      r_mosi      <= r_mosi_meta;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_load      <= r_rd;
      if (w_csn_rise) begin
        r_sel    <= 1'b0;
        r_bitcnt <= '0;
        r_rx     <= '0;
        r_tx     <= '0;
        if (r_state == PROG_DATA) r_wel <= 1'b0;
      end else if (w_csn_fall) begin
        r_sel    <= 1'b1;
        r_bitcnt <= '0;
        r_rx     <= '0;
        r_tx     <= '0;
      end else if (r_sel) begin
        if (w_sck_rise) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_rx     <= w_byte;
        end
        // the fall right after a byte boundary keeps the freshly loaded MSB on miso
        if (w_sck_fall && r_bitcnt != 3'd0) r_tx <= {r_tx[6:0], 1'b0};
        if (r_load && r_state == READ_DATA) r_tx <= bus.mem_rdata;
        if (r_wr) r_addr <= {r_addr[ADDR_W-1:PAGE_W], r_addr[PAGE_W-1:0] + PAGE_W'(1)};
        if (w_byte_done)
          case (r_state)
            CMD: begin
              r_tx       <= (w_byte == OP_RDID) ? JEDEC_ID[23:16] : (w_byte == OP_RDSR) ? w_status : 8'h00;
              r_fixed    <= JEDEC_ID[15:0];
              r_sr       <= w_byte == OP_RDSR;
              r_read     <= w_byte == OP_READ;
              r_addr_cnt <= '0;
              if (w_byte == OP_WREN) r_wel <= 1'b1;
              else if (w_byte == OP_WRDI) r_wel <= 1'b0;
            end
            ADDR: begin
              r_addr     <= ADDR_W'({r_addr, w_byte});
              r_addr_cnt <= r_addr_cnt + 2'd1;
              r_rd       <= r_read && r_addr_cnt == 2'd2;
            end
            READ_DATA: begin
              r_addr <= r_addr + ADDR_W'(1);
              r_rd   <= 1'b1;
            end
            PROG_DATA: begin
              r_wr    <= 1'b1;
              r_wdata <= w_byte;
            end
            TX_FIXED: begin
              r_tx    <= r_sr ? w_status : r_fixed[15:8];
              r_fixed <= {r_fixed[7:0], 8'hFF};
            end
            default: ;
          endcase
      end
    end
  end
  assign bus.spi_miso    = r_tx[7];
  assign bus.spi_miso_oe = r_sel;
  assign bus.active      = r_sel;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_rd      = r_rd;
  assign bus.mem_wr      = r_wr;
  assign bus.mem_wdata   = r_wdata;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI transactions against the flash responder with a byte memory model.
module tb_spi_flash_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic        both_seen = 1'b0;
  logic [7:0]  rx;
  spi_flash_responder_if #(.ADDR_W(24)) bus();
  spi_flash_responder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.mem_rdata <= bus.mem_addr[7:0];
  always @(negedge clk) begin
    if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
    if (bus.mem_wr) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_rd && bus.mem_wr) both_seen <= 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xfer(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nb; i--) begin
      bus.spi_mosi = b[i];
      clks(8);
      r[i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      clks(8);
      bus.spi_sck = 1'b0;
    end
  endtask
  task automatic send(input logic [7:0] b);
    xfer(b, 8, rx);
  endtask
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    xfer(8'h00, 8, rx);
    chk(tag, rx, exp);
  endtask
  task automatic sel();
    bus.spi_csn = 1'b0;
    clks(8);
    chk("sel", {bus.active, bus.spi_miso_oe, bus.spi_miso}, 3'b110);
  endtask
  task automatic desel();
    clks(4);
    bus.spi_csn = 1'b1;
    clks(8);
    chk("desel", {bus.active, bus.spi_miso_oe, bus.spi_miso}, 3'b000);
  endtask
  initial begin
    bus.spi_sck = 1'b0;
    bus.spi_csn = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.mem_busy = 1'b0;
    clks(4);
    chk("rst_ctl", {bus.spi_miso, bus.spi_miso_oe, bus.active, bus.mem_rd, bus.mem_wr}, 5'b0);
    chk("rst_addr", bus.mem_addr, 24'h0);
    chk("rst_wdata", bus.mem_wdata, 8'h00);
    reset = 1'b0;
    clks(4);
    chk("idle_ctl", {bus.spi_miso, bus.spi_miso_oe, bus.active, bus.mem_rd, bus.mem_wr}, 5'b0);
    sel(); send(8'h9F);
    expect_byte("rdid0", 8'hEF); expect_byte("rdid1", 8'h40); expect_byte("rdid2", 8'h16);
    expect_byte("rdid_fill", 8'hFF);
    desel();
    chk("rdid_nomem", rd_q.size() + wr_q.size(), 0);
    bus.mem_busy = 1'b1;
    sel(); send(8'h05); expect_byte("rdsr_busy", 8'h01); desel();
    bus.mem_busy = 1'b0;
    sel(); send(8'h06); desel();
    sel(); send(8'h05); expect_byte("rdsr_wel", 8'h02); expect_byte("rdsr_rep", 8'h02); desel();
    rd_q.delete();
    sel(); send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    expect_byte("rd0", 8'h10); expect_byte("rd1", 8'h11); expect_byte("rd2", 8'h12); expect_byte("rd3", 8'h13);
    desel();
    chk("rd_cnt", rd_q.size(), 5);
    for (int i = 0; i < 4; i++) chk("rd_addr", rd_q[i], 24'h10 + i);
    chk("rd_nowr", wr_q.size(), 0);
    wr_q.delete();
    sel(); send(8'h06); desel();
    sel(); send(8'h02); send(8'h00); send(8'h01); send(8'hFE);
    send(8'hAA); send(8'hBB); send(8'hCC);
    desel();
    chk("pp_cnt", wr_q.size(), 3);
    chk("pp_w0", wr_q[0], 32'h0001FEAA);
    chk("pp_w1", wr_q[1], 32'h0001FFBB);
    chk("pp_wrap", wr_q[2], 32'h000100CC);
    sel(); send(8'h05); expect_byte("wel_clr", 8'h00); desel();
    wr_q.delete();
    sel(); send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h11); send(8'h22); desel();
    chk("pp_nowel", wr_q.size(), 0);
    rd_q.delete();
    sel(); send(8'h03); send(8'hFF); send(8'hFF); send(8'hFF);
    expect_byte("rdw0", 8'hFF); expect_byte("rdw1", 8'h00);
    desel();
    chk("rdw_a0", rd_q[0], 24'hFFFFFF);
    chk("rdw_a1", rd_q[1], 24'h000000);
    wr_q.delete();
    sel(); send(8'h06); desel();
    sel(); send(8'h02); send(8'h00); send(8'h00); send(8'h20); xfer(8'h5A, 4, rx); desel();
    chk("abort_nowr", wr_q.size(), 0);
    sel(); send(8'h9F); expect_byte("after_abort", 8'hEF); desel();
    sel(); send(8'h05); expect_byte("abort_wel", 8'h00); desel();
    sel(); send(8'h03); send(8'h00); send(8'h00); send(8'h05); xfer(8'h00, 4, rx);
    reset = 1'b1;
    #1;
    chk("rst_mid_ctl", {bus.spi_miso, bus.spi_miso_oe, bus.active, bus.mem_rd, bus.mem_wr}, 5'b0);
    chk("rst_mid_addr", bus.mem_addr, 24'h0);
    clks(2);
    bus.spi_csn = 1'b1;
    clks(4);
    reset = 1'b0;
    clks(4);
    chk("rd_wr_excl", both_seen, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
SPI mode-0 responder that emulates a 25-series serial flash, the target end of the bootloader's SPI flash master. It oversamples external sck/csn/mosi in the system clock domain and decodes a command subset: JEDEC ID, read status, write enable/disable, read and page program. Array accesses are forwarded to a byte-wide memory port (BRAM or SDRAM front end). It serves as a flash stand-in for bootloader bring-up and as a loopback target on a second board.

Parameters:
JEDEC_ID, 24'hEF4016, three ID bytes returned MSB-first for command 0x9F
ADDR_W, 24, address width; addresses wrap modulo 2^ADDR_W
PAGE_W, 8, page-program wrap width (low PAGE_W address bits wrap within the page)

Ports:
clk  input  1  system clock; must be at least 8x the sck frequency
reset  input  1  asynchronous, active-high
spi_sck  input  1  external SPI clock (asynchronous)
spi_csn  input  1  external chip select, active low (asynchronous)
spi_mosi  input  1  external serial data in
spi_miso  output  1  serial data out
spi_miso_oe  output  1  miso drive enable
mem_addr  output  ADDR_W  byte address
mem_rd  output  1  one-cycle read strobe
mem_rdata  input  8  read data, valid exactly 1 clk after mem_rd
mem_wr  output  1  one-cycle write strobe
mem_wdata  output  8  write data, valid with mem_wr
mem_busy  input  1  reported as status WIP (bit 0)
active  output  1  high while csn is asserted (synchronised)

Behaviour:
- Interface as decided: single clock clk; reset asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; WEL=0; shift registers cleared.
- Synchronisation: sck, csn and mosi each pass through a 2-flop synchroniser. Edge detect on the synchronised sck. mosi is sampled on the sck rise; miso changes on the sck fall. Latency from pin to action is 3 clk.
- csn rise, from any state: return to IDLE next clk. Clears the bit counter, drops spi_miso_oe and active, and aborts any partial byte with no mem_wr. If the state was PROG_DATA at the rise, WEL clears.
- csn fall: enter CMD and set spi_miso_oe=1. MISO is 0 unless transmitting.
- Bit counter is 3 bits. A byte completes on the 8th sampled rise. Bytes are MSB first.
- CMD, on byte complete, dispatches by opcode:
  - 0x9F -> TX_FIXED, loaded with JEDEC_ID (3 bytes; then 0xFF repeats).
  - 0x05 -> TX_FIXED, status {6'b0, WEL, mem_busy}, repeated every byte and re-sampled at each byte boundary.
  - 0x06 -> WEL=1, then IGNORE.
  - 0x04 -> WEL=0, then IGNORE.
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (program).
  - anything else -> IGNORE until csn rises.
- ADDR collects 3 bytes into the address; bits above ADDR_W are discarded. On the 3rd byte complete:
  - Read: pulse mem_rd with mem_addr=addr, latch mem_rdata the next clk into the tx shift register, then enter READ_DATA.
  - Program with WEL=1: enter PROG_DATA.
  - Program with WEL=0: enter IGNORE.
- READ_DATA:
  - The first data bit must be on miso before the sck fall that follows the last address bit. The 8x clock ratio guarantees this.
  - At each byte complete: addr <= addr+1, wrapping modulo 2^ADDR_W, then issue mem_rd and reload the tx register.
- PROG_DATA: each complete byte issues mem_wr with mem_wdata=byte and mem_addr=addr. The low PAGE_W bits then increment with wrap; the upper bits are held.
- mem_rd and mem_wr are never asserted in the same clk. Each is exactly one clk per byte.
- Simultaneous csn rise and byte-complete in the same synchronised cycle: csn wins and no strobe is issued.
- Reset mid-transaction: immediate return to reset values. The transaction is lost; the master must re-select.

Decomposition:
- Package spi_flash_pkg holds:
  - opcode constants: OP_READ=0x03, OP_PP=0x02, OP_RDSR=0x05, OP_WREN=0x06, OP_WRDI=0x04, OP_RDID=0x9F;
  - the state enum: IDLE, CMD, ADDR, READ_DATA, PROG_DATA, TX_FIXED, IGNORE.
- One sub-module, spi_sync_edge: a 2-flop synchroniser plus rise/fall detect, instantiated for sck and csn. mosi uses its synchroniser only.

Test Plan:
- 0x9F followed by 3 dummy bytes -> miso bytes EF 40 16; no mem strobes.
- 0x05 with WEL=0 and mem_busy=1 -> 0x01. Then 0x06 followed by 0x05 -> 0x02.
- 0x03 00 00 10 followed by 4 bytes, with the memory model returning addr[7:0] -> miso 10 11 12 13; mem_rd pulses at addr 0x10..0x13.
- 0x06 then 0x02 00 01 FE followed by data AA BB CC -> mem_wr at 0x0001FE=AA, 0x0001FF=BB, 0x000100=CC (page wrap). WEL=0 after csn rise.
- 0x02 without a prior WREN -> no mem_wr.
- 0x03 FF FF FF followed by 2 bytes -> reads at 0xFFFFFF then 0x000000 (address wrap).
- csn raised after 4 bits of a program data byte -> no mem_wr; next command decodes normally.
- Reset asserted mid-read -> all outputs 0 within 1 clk.
